// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: circular queue of fetched words feeding decode one instruction per
// accept. Define PREFETCH_RVC_EN to enable 16-bit compressed parcels and halfword alignment.
module fetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_compressed
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = CW + 1;

`ifdef PREFETCH_RVC_EN
    localparam logic        RESET_HOFF = RESET_PC[1];
    localparam logic [31:0] RESET_CUR  = RESET_PC;
`else
    localparam logic        RESET_HOFF = 1'b0;
    localparam logic [31:0] RESET_CUR  = {RESET_PC[31:2], 2'b00};
`endif

    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          hoff_q, hoff_d;
    logic [31:0]   fetch_addr_q, fetch_addr_d;
    logic [31:0]   cur_pc_q, cur_pc_d;

    logic [31:0]   head_word, next_word;
    logic [15:0]   p0, p1;
    logic [AW-1:0] avail;
    logic          is_comp, valid_raw;
    logic [31:0]   data_raw;
    logic [1:0]    consume_pos;
    logic          ack_take, accept;

    assign head_word = mem_q[rptr_q];
    assign next_word = mem_q[rptr_q + PW'(1)];

    always_comb begin
        p0    = hoff_q ? head_word[31:16] : head_word[15:0];
        p1    = hoff_q ? next_word[15:0]  : head_word[31:16];
        avail = {count_q, 1'b0} - AW'(hoff_q);
`ifdef PREFETCH_RVC_EN
        is_comp = (p0[1:0] != 2'b11);
`else
        is_comp = 1'b0;
`endif
        // count_q != 0 also guards avail against underflow when hoff is set on an empty buffer
        valid_raw   = (count_q != '0) && (is_comp || (avail >= AW'(2)));
        data_raw    = is_comp ? {16'h0000, p0} : {p1, p0};
        consume_pos = {1'b0, hoff_q} + (is_comp ? 2'd1 : 2'd2);
    end

    assign imem_req        = !reset && (count_q < CW'(DEPTH)) && !redirect_valid;
    assign imem_addr       = fetch_addr_q;
    assign inst_valid      = !reset && valid_raw;
    assign inst_data       = reset ? 32'h0000_0000 : data_raw;
    assign inst_compressed = !reset && is_comp;
    assign inst_pc         = cur_pc_q;

    assign ack_take = imem_req && imem_ack;
    assign accept   = inst_valid && inst_ready;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        hoff_d       = hoff_q;
        fetch_addr_d = fetch_addr_q;
        cur_pc_d     = cur_pc_q;
        if (redirect_valid) begin
            wptr_d       = '0;
            rptr_d       = '0;
            count_d      = '0;
            fetch_addr_d = redirect_pc & 32'hFFFF_FFFC;
`ifdef PREFETCH_RVC_EN
            hoff_d   = redirect_pc[1];
            cur_pc_d = redirect_pc;
`else
            hoff_d   = 1'b0;
            cur_pc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else begin
            if (ack_take) begin
                wptr_d       = wptr_q + PW'(1);
                fetch_addr_d = fetch_addr_q + 32'd4;
            end
            if (accept) begin
                // Carry out of the halfword position means the head word is fully consumed
                rptr_d   = rptr_q + PW'(consume_pos[1]);
                hoff_d   = consume_pos[0];
                cur_pc_d = cur_pc_q + (is_comp ? 32'd2 : 32'd4);
            end
            count_d = count_q + CW'(ack_take) - CW'(accept && consume_pos[1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            hoff_q       <= RESET_HOFF;
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            cur_pc_q     <= RESET_CUR;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            hoff_q       <= hoff_d;
            fetch_addr_q <= fetch_addr_d;
            cur_pc_q     <= cur_pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ack_take) begin
            mem_q[wptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: directed scenarios plus random traffic checked against an
// address-level model of the instruction stream (memory image + buffered word count).
module tb_fetch_prefetch_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_compressed;

    fetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc),
        .inst_compressed (inst_compressed)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory image: directed overrides, otherwise a hash of the address
    logic [31:0] ovr [logic [31:0]];

    // Model: words buffered, address of the head word, presented pc, next fetch address
    int          mcount;
    logic [31:0] mbase, mpc, mfetch;
    bit          exp_req, exp_valid, exp_comp;
    logic [31:0] exp_data;

    function automatic logic [31:0] img_word(input logic [31:0] a);
        logic [31:0] w;
        if (ovr.exists(a)) return ovr[a];
        w = a * 32'h9E37_79B1 + 32'h7F4A_7C15;
        return w ^ (w >> 15);
    endfunction

    function automatic logic [15:0] img_hw(input logic [31:0] a);
        logic [31:0] w;
        w = img_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_expect();
        int          off_h;
        int          avail_h;
        logic [15:0] p0;
        exp_req   = (mcount < DEPTH) && !redirect_valid;
        off_h     = int'((mpc - mbase) >> 1);
        avail_h   = 2 * mcount - off_h;
        p0        = img_hw(mpc);
        exp_comp  = RVC && (p0[1:0] != 2'b11);
        exp_valid = exp_comp ? (avail_h >= 1) : (avail_h >= 2);
        exp_data  = exp_comp ? {16'h0000, p0} : {img_hw(mpc + 32'd2), p0};
    endtask

    task automatic model_reset();
        mcount = 0;
        mfetch = RESET_PC & 32'hFFFF_FFFC;
        mbase  = mfetch;
        mpc    = RVC ? RESET_PC : mfetch;
    endtask

    // One clock: drive at negedge, check just after, update the model at the posedge
    task automatic step(input bit ack, input bit ready, input bit redir, input logic [31:0] rpc);
        bit took, acc;
        imem_ack       = ack;
        imem_rdata     = ack ? img_word(mfetch) : $urandom;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
        model_expect();
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", imem_addr, mfetch);
        chk("inst_valid", 32'(inst_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("inst_data", inst_data, exp_data);
            chk("inst_pc", inst_pc, mpc);
            chk("inst_compressed", 32'(inst_compressed), 32'(exp_comp));
        end
        took = exp_req && ack;
        acc  = exp_valid && ready;
        @(posedge clk);
        if (redir) begin
            mcount = 0;
            mfetch = rpc & 32'hFFFF_FFFC;
            mbase  = mfetch;
            mpc    = RVC ? rpc : mfetch;
        end else begin
            if (took) begin
                mcount++;
                mfetch = mfetch + 32'd4;
            end
            if (acc) begin
                mpc = mpc + (exp_comp ? 32'd2 : 32'd4);
                while ((mpc - mbase) >= 32'd4) begin
                    mbase = mbase + 32'd4;
                    mcount--;
                end
            end
        end
        @(negedge clk);
    endtask

    // Holds reset across one posedge with an ack offered; starts and ends at a negedge
    task automatic apply_reset();
        reset          = 1'b1;
        imem_ack       = 1'b1;
        imem_rdata     = $urandom;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_compressed", 32'(inst_compressed), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] rpc;
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        @(negedge clk);

        // Straight-line stream of 32-bit NOPs
        for (int a = 0; a < 64; a += 4) ovr[32'(a)] = 32'h0000_0013;
        apply_reset();
        chk("r036_first_addr", imem_addr, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("r036_valid_after_ack", 32'(inst_valid), 32'h1);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("r036_pc", inst_pc, 32'h4);
        chk("r036_addr", imem_addr, 32'h8);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

        // Mixed compressed / 32-bit words
        ovr[32'h0] = 32'h4501_4505;
        ovr[32'h4] = 32'h00A0_0093;
        apply_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef PREFETCH_RVC_EN
        chk("r037_data0", inst_data, 32'h0000_4505);
        chk("r037_comp0", 32'(inst_compressed), 32'h1);
        chk("r037_pc0", inst_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("r037_data1", inst_data, 32'h0000_4501);
        chk("r037_pc1", inst_pc, 32'h2);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("r037_data2", inst_data, 32'h00A0_0093);
        chk("r037_pc2", inst_pc, 32'h4);
`else
        chk("r041_data0", inst_data, 32'h4501_4505);
        chk("r041_comp0", 32'(inst_compressed), 32'h0);
        chk("r041_pc0", inst_pc, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("r041_data1", inst_data, 32'h00A0_0093);
        chk("r041_pc1", inst_pc, 32'h4);
`endif
        step(1'b0, 1'b1, 1'b0, 32'h0);

        // Redirect into the middle of a word; spanning 32-bit instruction
        ovr[32'h100] = 32'h0093_4501;
        ovr[32'h104] = 32'hABCD_0050;
        step(1'b0, 1'b0, 1'b1, 32'h102);
        chk("r038_addr", imem_addr, 32'h100);
        chk("r038_valid_empty", 32'(inst_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
`ifdef PREFETCH_RVC_EN
        chk("r038_valid_one_word", 32'(inst_valid), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("r038_valid_two_words", 32'(inst_valid), 32'h1);
        chk("r038_data", inst_data, 32'h0050_0093);
        chk("r038_pc", inst_pc, 32'h102);
`else
        chk("r038_data_aligned", inst_data, 32'h0093_4501);
        chk("r038_pc_aligned", inst_pc, 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0);
`endif

        // Back-pressure: buffer fills, request drops, one accept reopens it
        ovr[32'h0] = 32'h0000_0013;
        apply_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("r039_req_full", 32'(imem_req), 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("r039_req_reopen", 32'(imem_req), 32'h1);

        // Redirect with a same-cycle ack
        step(1'b1, 1'b1, 1'b1, 32'h40);
        chk("r040_addr", imem_addr, 32'h40);
        chk("r040_valid", 32'(inst_valid), 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic, including redirects near the top of the address space
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 699) apply_reset();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000E);
            else                           rpc = $urandom & 32'hFFFF_FFFE;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, rpc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
